fetch_unit: RTL and testbench

//  Instruction fetch stage: owns the fetch PC and drives requests to instruction memory with a req/ack handshake.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, fetches one word at a time over a req/ack
// handshake and presents it with its PC and decode fields. Optional FETCH_COUNT_EN adds fetchCount.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        nReset,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [6:0]  opcode,
  output logic [3:0]  ctrl
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0] fetchCount
`endif
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcodes_t;

  typedef logic [3:0] alucodes_t;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  opcodes_t    op;
  logic        qual;
  alucodes_t   alu;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirectPC[1:0];
  assign imemAddr = fetch_pc;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      imemReq    <= 1'b0;
      instrValid <= 1'b0;
      instr      <= NOP_INSTR;
      pc         <= RESET_PC;
    end else if (redirect) begin
      // The IDLE detour guarantees imemReq drops for a cycle before the new address goes out.
      state      <= IDLE;
      fetch_pc   <= {redirectPC[31:2], 2'b00};
      imemReq    <= 1'b0;
      instrValid <= 1'b0;
      instr      <= NOP_INSTR;
    end else begin
      case (state)
        IDLE: begin
          state   <= REQ;
          imemReq <= 1'b1;
        end
        REQ: begin
          if (imemAck) begin
            state      <= HOLD;
            imemReq    <= 1'b0;
            instr      <= imemData;
            pc         <= fetch_pc;
            instrValid <= 1'b1;
            fetch_pc   <= fetch_pc + 32'd4;
          end
        end
        HOLD: begin
          if (advance) begin
            state      <= REQ;
            imemReq    <= 1'b1;
            instrValid <= 1'b0;
            instr      <= NOP_INSTR;
          end
        end
        default: begin
          state   <= IDLE;
          imemReq <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
  assign fetchCount = fetch_count;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset)
      fetch_count <= 32'd0;
    else if (!redirect && state == REQ && imemAck)
      fetch_count <= fetch_count + 32'd1;
  end
`endif

  // Shift/subtract qualifier: funct7[5] only matters for OP and for the OPIMM right shifts.
  assign op = opcodes_t'(instr[6:0]);

  always_comb begin
    qual = 1'b0;
    case (op)
      OPC_OP:    qual = 1'b1;
      OPC_OPIMM: qual = (instr[14:12] == 3'b101);
      default:   qual = 1'b0;
    endcase
  end

  assign alu    = {instr[30] & qual, instr[14:12]};
  assign opcode = instr[6:0];
  assign ctrl   = alu;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps then random handshake traffic against a cycle-level
// behavioural model of the fetch rules.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        imemAck = 1'b0;
  logic [31:0] imemData = 32'd0;
  logic        advance = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPC = 32'd0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [3:0]  ctrl;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetchCount;
`endif

  fetch_unit dut (
    .clock(clock), .nReset(nReset),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .advance(advance), .redirect(redirect), .redirectPC(redirectPC),
    .instrValid(instrValid), .instr(instr), .pc(pc), .opcode(opcode), .ctrl(ctrl)
`ifdef FETCH_COUNT_EN
    , .fetchCount(fetchCount)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Model: m_gap = one dead cycle pending after reset/redirect; m_have = instruction presented.
  bit          m_gap;
  bit          m_have;
  logic [31:0] m_fetch;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [31:0] m_count;

  task automatic model_reset();
    m_gap = 1'b1; m_have = 1'b0; m_fetch = 32'd0;
    m_instr = NOP; m_pc = 32'd0; m_count = 32'd0;
  endtask

  function automatic logic [3:0] ref_ctrl(logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    if (w[6:0] == 7'h33) return {w[30], f3};
    if (w[6:0] == 7'h13 && f3 == 3'd5) return {w[30], f3};
    return {1'b0, f3};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imemReq", {31'd0, imemReq}, {31'd0, !m_gap && !m_have});
    chk("imemAddr", imemAddr, m_fetch);
    chk("instrValid", {31'd0, instrValid}, {31'd0, m_have});
    chk("instr", instr, m_instr);
    chk("pc", pc, m_pc);
    chk("opcode", {25'd0, opcode}, {25'd0, m_instr[6:0]});
    chk("ctrl", {28'd0, ctrl}, {28'd0, ref_ctrl(m_instr)});
`ifdef FETCH_COUNT_EN
    chk("fetchCount", fetchCount, m_count);
`endif
  endtask

  // Apply one clock edge with the currently driven inputs, advance the model, then check.
  task automatic tick();
    if (redirect) begin
      m_fetch = {redirectPC[31:2], 2'b00};
      m_have = 1'b0; m_instr = NOP; m_gap = 1'b1;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (!m_have) begin
      if (imemAck) begin
        m_have = 1'b1; m_instr = imemData; m_pc = m_fetch;
        m_fetch = m_fetch + 32'd4; m_count = m_count + 32'd1;
      end
    end else if (advance) begin
      m_have = 1'b0; m_instr = NOP;
    end
    @(posedge clock);
    #1;
    check_all();
    $display("cycle req=%0b addr=%h ack=%0b adv=%0b redir=%0b valid=%0b instr=%h pc=%h",
             imemReq, imemAddr, imemAck, advance, redirect, instrValid, instr, pc);
  endtask

  task automatic fetch_word(logic [31:0] w);
    imemAck = 1'b1; imemData = w;
    tick();
    imemAck = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", {31'd0, imemReq}, 32'd0);
    chk("rst_valid", {31'd0, instrValid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, 32'd0);
    chk("rst_ctrl", {28'd0, ctrl}, 32'd0);
    nReset = 1'b1;

    // First fetch with ack one cycle after request
    tick();
    chk("first_addr", imemAddr, 32'h0);
    fetch_word(32'h00A3_0333);
    chk("first_pc", pc, 32'h0);
    chk("next_addr", imemAddr, 32'h4);

    // Stall in HOLD for 5 cycles
    repeat (5) tick();
    chk("hold_opcode", {25'd0, opcode}, 32'h33);
    chk("hold_ctrl", {28'd0, ctrl}, 32'h0);
    chk("hold_req", {31'd0, imemReq}, 32'd0);

    // Delayed ack: address stable three cycles, no valid until ack edge
    advance = 1'b1; tick(); advance = 1'b0;
    repeat (3) begin
      tick();
      chk("delay_addr", imemAddr, 32'h4);
      chk("delay_valid", {31'd0, instrValid}, 32'd0);
    end
    fetch_word(32'h4020_0033);
    chk("sub_ctrl", {28'd0, ctrl}, 32'h8);
    advance = 1'b1; tick(); advance = 1'b0;
    fetch_word(32'h4010_5013);
    chk("srai_ctrl", {28'd0, ctrl}, 32'hD);
    advance = 1'b1; tick(); advance = 1'b0;
    fetch_word(32'h4000_0013);
    chk("addi_ctrl", {28'd0, ctrl}, 32'h0);

    // Redirect colliding with an ack
    advance = 1'b1; tick(); advance = 1'b0;
    redirect = 1'b1; redirectPC = 32'h0000_0102; imemAck = 1'b1; imemData = 32'hDEAD_BEEF;
    tick();
    redirect = 1'b0; imemAck = 1'b0;
    chk("redir_valid", {31'd0, instrValid}, 32'd0);
    chk("redir_gap", {31'd0, imemReq}, 32'd0);
    tick();
    chk("redir_addr", imemAddr, 32'h0000_0100);
    chk("redir_req", {31'd0, imemReq}, 32'd1);
`ifdef FETCH_COUNT_EN
    chk("count4", fetchCount, 32'd4);
`endif

    // PC wrap at the top of the address space
    redirect = 1'b1; redirectPC = 32'hFFFF_FFFE; tick(); redirect = 1'b0;
    tick();
    fetch_word(32'h0000_0033);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imemAddr, 32'h0);

    // Redirect and advance together in HOLD
    redirect = 1'b1; advance = 1'b1; redirectPC = 32'h0000_0040; tick();
    redirect = 1'b0; advance = 1'b0;
    chk("redir_adv_req", {31'd0, imemReq}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      imemAck = ($urandom_range(0, 2) == 0);
      imemData = $urandom;
      advance = ($urandom_range(0, 1) == 0);
      redirect = ($urandom_range(0, 15) == 0);
      redirectPC = $urandom;
      tick();
    end
    imemAck = 1'b0; advance = 1'b0; redirect = 1'b0;

    // Asynchronous reset in the middle of a request
    redirect = 1'b1; redirectPC = 32'h0000_0200; tick(); redirect = 1'b0;
    tick();
    chk("pre_rst_req", {31'd0, imemReq}, 32'd1);
    #2 nReset = 1'b0;
    #1;
    chk("async_req", {31'd0, imemReq}, 32'd0);
    chk("async_addr", imemAddr, 32'h0);
    chk("async_valid", {31'd0, instrValid}, 32'd0);
    chk("async_instr", instr, NOP);
    chk("async_pc", pc, 32'h0);
    model_reset();
    @(posedge clock);
    #1 nReset = 1'b1;
    tick();
    fetch_word(32'h0000_0013);
    chk("post_rst_pc", pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
